// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: one RAM slot per cycle, shared between scan-out reads,
// a clear-screen sweep and a small CPU write FIFO (priority in that order).
module vga_fb_arbiter #(
  parameter int unsigned CD         = 12,
  parameter int unsigned AW         = 17,
  parameter int unsigned FB_SIZE    = 76800,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_req_i,
  input  logic [AW-1:0]                 wr_addr_i,
  input  logic [CD-1:0]                 wr_data_i,
  output logic                          wr_ready_o,
  input  logic                          rd_req_i,
  input  logic [AW-1:0]                 rd_addr_i,
  output logic                          rd_valid_o,
  output logic [CD-1:0]                 rd_data_o,
  input  logic                          clr_req_i,
  input  logic [CD-1:0]                 clr_color_i,
  output logic                          clr_busy_o,
  output logic                          clr_done_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic [AW-1:0]                 mem_addr_o,
  output logic [CD-1:0]                 mem_wdata_o,
  input  logic [CD-1:0]                 mem_rdata_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          starve_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic {StIdle, StClear} state_e;

  state_e        r_state;
  logic [AW-1:0] r_clr_addr;
  logic          r_clr_done;

  logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [CD-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          r_rd_pend;
  logic          r_rd_valid;
  logic [CD-1:0] r_rd_data;

  logic [15:0]   r_starve_cnt;
  logic          r_starve;

  logic w_empty, w_ready, w_push, w_rd, w_clr, w_pop, w_stall, w_last_clr;

  // Ready comes only from the registered level, so a full FIFO refuses pushes
  // even in a cycle where it also pops.
  assign w_empty    = (r_level == '0);
  assign w_ready    = (r_level < LW'(FIFO_DEPTH));
  assign w_push     = wr_req_i & w_ready & ~reset;
  assign w_rd       = rd_req_i & ~reset;
  assign w_clr      = ~reset & ~rd_req_i & (r_state == StClear);
  assign w_pop      = ~reset & ~rd_req_i & (r_state == StIdle) & ~w_empty;
  assign w_stall    = ~w_empty & ~w_pop;
  assign w_last_clr = (r_clr_addr == AW'(FB_SIZE - 1));

  // FIFO storage; contents need no reset since the level gates every use
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr_i;
      r_fifo_data[r_wptr] <= wr_data_i;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointer wrap implicit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
    end
  end

  // Clear-screen FSM: sweeps 0..FB_SIZE-1 on granted slots, pulses done after the last
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_clr_addr <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      if (r_state == StIdle) begin
        if (clr_req_i) begin
          r_state    <= StClear;
          r_clr_addr <= '0;
        end
      end else if (w_clr) begin
        if (w_last_clr) begin
          r_state    <= StIdle;
          r_clr_done <= 1'b1;
        end else begin
          r_clr_addr <= r_clr_addr + AW'(1);
        end
      end
    end
  end

  // Read return pipeline: RAM data arrives one cycle after the slot, registered once more
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend  <= w_rd;
      r_rd_valid <= r_rd_pend;
      if (r_rd_pend) r_rd_data <= mem_rdata_i;
    end
  end

  // Starvation watchdog: counts cycles with queued writes but no pop; flag is sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
    end else begin
      if (!w_stall)                     r_starve_cnt <= '0;
      else if (r_starve_cnt != 16'hFFFF) r_starve_cnt <= r_starve_cnt + 16'd1;
      if (w_stall && (r_starve_cnt >= 16'd1022)) r_starve <= 1'b1;
    end
  end

  // RAM port driven straight from this cycle's slot decision
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_rd) begin
      mem_en_o   = 1'b1;
      mem_addr_o = rd_addr_i;
    end else if (w_clr) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = r_clr_addr;
      mem_wdata_o = clr_color_i;
    end else if (w_pop) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = r_fifo_addr[r_rptr];
      mem_wdata_o = r_fifo_data[r_rptr];
    end
  end

  assign wr_ready_o   = w_ready;
  assign rd_valid_o   = r_rd_valid;
  assign rd_data_o    = r_rd_data;
  assign clr_busy_o   = (r_state == StClear);
  assign clr_done_o   = r_clr_done;
  assign fifo_level_o = r_level;
  assign starve_o     = r_starve;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed stimulus, a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_vga_fb_arbiter;

  localparam int CD  = 12;
  localparam int AW  = 17;
  localparam int FBS = 8;
  localparam int FD  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, rd_req, clr_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [CD-1:0] wr_data, clr_color;
  logic          wr_ready, rd_valid, clr_busy, clr_done;
  logic [CD-1:0] rd_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [CD-1:0] mem_wdata;
  logic [CD-1:0] mem_rdata = '0;
  logic [2:0]    fifo_level;
  logic          starve;

  vga_fb_arbiter #(.CD(CD), .AW(AW), .FB_SIZE(FBS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .clr_req_i(clr_req), .clr_color_i(clr_color), .clr_busy_o(clr_busy),
    .clr_done_o(clr_done), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .fifo_level_o(fifo_level),
    .starve_o(starve)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM seen by the DUT
  logic [CD-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  // Reference model: FIFO as a queue, sweep as an index, reads as timestamped returns
  typedef struct { logic [AW-1:0] a; logic [CD-1:0] d; } wr_t;
  typedef struct { int due; logic [CD-1:0] d; } rd_t;
  wr_t           q[$];
  rd_t           rdq[$];
  logic [CD-1:0] shadow [256];
  bit            m_busy = 0, m_done = 0, m_starve = 0;
  int            m_idx = 0, stall = 0, cyc = 0;
  logic [CD-1:0] m_last = '0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    ram[16]    = 12'hABC;
    shadow[16] = 12'hABC;
  end

  // slot codes: 0 idle, 1 read, 2 clear write, 3 FIFO write
  always @(negedge clk) begin
    int s, n;
    bit exp_rv, nd;
    logic [CD-1:0] exp_rd;
    #4;
    if (reset)           s = 0;
    else if (rd_req)     s = 1;
    else if (m_busy)     s = 2;
    else if (q.size > 0) s = 3;
    else                 s = 0;
    exp_rv = (rdq.size() > 0) && (rdq[0].due == cyc);
    exp_rd = exp_rv ? rdq[0].d : m_last;
    if (chk_en) begin
      chk("mem_en", 32'(mem_en), 32'(s != 0));
      chk("mem_we", 32'(mem_we), 32'(s >= 2));
      if (s == 1) chk("mem_addr_rd", 32'(mem_addr), 32'(rd_addr));
      if (s == 2) begin
        chk("mem_addr_clr", 32'(mem_addr), 32'(m_idx));
        chk("mem_wdata_clr", 32'(mem_wdata), 32'(clr_color));
      end
      if (s == 3) begin
        chk("mem_addr_wr", 32'(mem_addr), 32'(q[0].a));
        chk("mem_wdata_wr", 32'(mem_wdata), 32'(q[0].d));
      end
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("wr_ready", 32'(wr_ready), 32'(q.size() < FD));
      chk("clr_busy", 32'(clr_busy), 32'(m_busy));
      chk("clr_done", 32'(clr_done), 32'(m_done));
      chk("starve", 32'(starve), 32'(m_starve));
      chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
      chk("rd_data", 32'(rd_data), 32'(exp_rd));
    end
    if (reset) begin
      q.delete();
      rdq.delete();
      m_busy = 0; m_done = 0; m_starve = 0; stall = 0; m_idx = 0; m_last = '0;
    end else begin
      n = q.size();
      if (exp_rv) begin
        m_last = rdq[0].d;
        void'(rdq.pop_front());
      end
      if (s == 1) rdq.push_back('{cyc + 2, shadow[rd_addr[7:0]]});
      if (s == 2) shadow[m_idx[7:0]] = clr_color;
      if (s == 3) begin
        shadow[q[0].a[7:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (wr_req && n < FD) q.push_back('{wr_addr, wr_data});
      if (n > 0 && s != 3) stall++;
      else                 stall = 0;
      if (stall >= 1023) m_starve = 1;
      nd = 0;
      if (m_busy) begin
        if (s == 2) begin
          if (m_idx == FBS - 1) begin
            m_busy = 0;
            nd = 1;
          end else begin
            m_idx++;
          end
        end
      end else if (clr_req) begin
        m_busy = 1;
        m_idx  = 0;
      end
      m_done = nd;
    end
    cyc++;
  end

  initial begin
    reset = 1; wr_req = 0; rd_req = 0; clr_req = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; clr_color = 12'h0F0;

    // reset overrides a read request
    @(negedge clk); chk_en = 1'b1; rd_req = 1; rd_addr = 17'h10;
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk); reset = 0; rd_req = 0;

    // read latency
    @(negedge clk); rd_req = 1; rd_addr = 17'h10;
    #1;
    chk("lat_en", 32'(mem_en), 32'd1);
    chk("lat_we", 32'(mem_we), 32'd0);
    chk("lat_addr", 32'(mem_addr), 32'h10);
    @(negedge clk); rd_req = 0;
    #1 chk("lat_valid_n1", 32'(rd_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("lat_valid_n2", 32'(rd_valid), 32'd1);
    chk("lat_data_n2", 32'(rd_data), 32'hABC);

    // FIFO fill under a held read; fifth write dropped
    @(negedge clk); rd_req = 1; rd_addr = 17'h10;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1; wr_addr = 17'h20 + 17'(i); wr_data = 12'h101 + 12'(i);
      if (i == 4) #1 chk("fill_ready_full", 32'(wr_ready), 32'd0);
      @(negedge clk);
    end
    wr_req = 0;
    #1 chk("fill_level", 32'(fifo_level), 32'd4);
    @(negedge clk); rd_req = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_we", 32'(mem_we), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'h20 + 32'(k));
      chk("drain_data", 32'(mem_wdata), 32'h101 + 32'(k));
      @(negedge clk);
    end
    rd_req = 1; rd_addr = 17'h24;
    @(negedge clk); rd_req = 0;
    @(negedge clk);
    #1 chk("dropped_word", 32'(rd_data), 32'd0);

    // interleave: reads on even cycles, queued writes fill the gaps
    @(negedge clk); rd_req = 1; rd_addr = 17'h30;
    for (int i = 0; i < 3; i++) begin
      wr_req = 1; wr_addr = 17'h50 + 17'(i); wr_data = 12'h201 + 12'(i);
      @(negedge clk);
    end
    wr_req = 0;
    for (int t = 0; t < 8; t++) begin
      rd_req = (t % 2 == 0); rd_addr = 17'h30 + 17'(t);
      #1;
      if (t % 2 == 0) begin
        chk("il_rd_we", 32'(mem_we), 32'd0);
        chk("il_rd_addr", 32'(mem_addr), 32'h30 + 32'(t));
      end else if (t < 6) begin
        chk("il_wr_addr", 32'(mem_addr), 32'h50 + 32'(t / 2));
      end else begin
        chk("il_idle_en", 32'(mem_en), 32'd0);
      end
      @(negedge clk);
    end
    rd_req = 0;

    // clear sweep with a mid-sweep push and an ignored re-request
    @(negedge clk); clr_req = 1; clr_color = 12'h0F0;
    @(negedge clk); clr_req = 0;
    for (int k = 0; k < FBS; k++) begin
      if (k == 2) begin wr_req = 1; wr_addr = 17'h40; wr_data = 12'h777; end
      if (k == 4) clr_req = 1;
      #1;
      chk("clr_busy", 32'(clr_busy), 32'd1);
      chk("clr_addr", 32'(mem_addr), 32'(k));
      chk("clr_wdata", 32'(mem_wdata), 32'h0F0);
      @(negedge clk);
      wr_req = 0; clr_req = 0;
    end
    #1;
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    chk("clr_after_addr", 32'(mem_addr), 32'h40);
    chk("clr_after_data", 32'(mem_wdata), 32'h777);
    @(negedge clk);
    #1;
    chk("clr_done_low", 32'(clr_done), 32'd0);
    chk("clr_no_restart", 32'(clr_busy), 32'd0);
    @(negedge clk); rd_req = 1; rd_addr = 17'h3;
    @(negedge clk); rd_addr = 17'h40;
    @(negedge clk); rd_req = 0;
    #1 chk("clr_read3", 32'(rd_data), 32'h0F0);
    @(negedge clk);
    #1 chk("clr_read40", 32'(rd_data), 32'h777);

    // starvation: one queued write behind a long read burst
    @(negedge clk); rd_req = 1; rd_addr = 17'h0; wr_req = 1; wr_addr = 17'h60;
    wr_data = 12'h333;
    @(negedge clk); wr_req = 0;
    for (int k = 1; k <= 1100; k++) begin
      if (k == 1023) #1 chk("starve_before", 32'(starve), 32'd0);
      if (k == 1024) #1 chk("starve_after", 32'(starve), 32'd1);
      @(negedge clk);
    end
    rd_req = 0;
    #1 chk("starve_drain_addr", 32'(mem_addr), 32'h60);
    repeat (3) @(negedge clk);
    #1;
    chk("starve_sticky", 32'(starve), 32'd1);
    chk("starve_level", 32'(fifo_level), 32'd0);

    // reset in the middle of a sweep, with a write queued
    @(negedge clk); clr_req = 1;
    @(negedge clk); clr_req = 0; wr_req = 1; wr_addr = 17'h70; wr_data = 12'h555;
    @(negedge clk); wr_req = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_addr3", 32'(mem_addr), 32'd3);
    chk("mid_level", 32'(fifo_level), 32'd1);
    reset = 1;
    #1 chk("mid_rst_en", 32'(mem_en), 32'd0);
    @(negedge clk); reset = 0;
    #1;
    chk("mid_busy", 32'(clr_busy), 32'd0);
    chk("mid_level0", 32'(fifo_level), 32'd0);
    chk("mid_starve", 32'(starve), 32'd0);
    for (int k = 0; k < 12; k++) begin
      #1 chk("mid_no_done", 32'(clr_done), 32'd0);
      @(negedge clk);
    end

    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
